scan_readback_intf: RTL and testbench

//  Downstream companion of the pseudo-SPI scan loader. Captures the parallel inputs (PIN) of an LSSD scan chain,

---
 rtl/scan_readback_intf_if.sv | 40 ++++
 rtl/scan_readback_intf.sv | 167 ++++++++++++++++
 tb/tb_scan_readback_intf.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_readback_intf_if.sv
// scan_readback_intf_if
//   Bundles the scan chain, SRAM and start/done signals of the scan readback
//   engine.
//   Handshake: bgn is a level request. The engine samples it only while idle.
//   It then raises done after the last SRAM write and keeps done high until
//   bgn is seen low. addr_bgn and data_len must be valid on the edge where bgn
//   is first seen high. They may change freely after that edge.
//   Modports:
//     slave  - the readback engine (drives scan clocks, SRAM strobes, done)
//     master - the requester and environment (drives bgn, addr_bgn, data_len, so)
//   Signals: bgn, addr_bgn, data_len, so, sel, sclk1, sclk2, si, cen, wen, a, d, done
interface scan_readback_intf_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
);
  logic              bgn;
  logic [ADDR_W-1:0] addr_bgn;
  logic [LEN_W-1:0]  data_len;
  logic              so;
  logic              sel;
  logic              sclk1;
  logic              sclk2;
  logic              si;
  logic              cen;
  logic              wen;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  logic              done;

  modport slave (
    input  bgn, addr_bgn, data_len, so,
    output sel, sclk1, sclk2, si, cen, wen, a, d, done
  );

  modport master (
    output bgn, addr_bgn, data_len, so,
    input  sel, sclk1, sclk2, si, cen, wen, a, d, done
  );
endinterface

// File: rtl/scan_readback_intf.sv
// scan_readback_intf
//   Captures the parallel inputs of an LSSD scan chain. It then shifts the
//   chain out with two-phase non-overlapping clocks (sclk1, gap, sclk2) and
//   packs the bits LSB-first into words. Each word is written to SRAM starting
//   at the latched addr_bgn. The address wraps modulo 2**MEMORY_ADDR_WIDTH.
//   Ports:
//     clk       - system clock, rising edge
//     rst       - synchronous reset, active high
//     bus       - scan_readback_intf_if.slave (scan, SRAM and bgn/done signals)
//     dbg_state - current FSM state, for observation only
//   Build option:
//     SCAN_RB_RECIRC_EN - when defined, si re-injects each bit read from so.
//                         A readback of exactly the chain length leaves the
//                         chain holding its captured contents. When undefined,
//                         si stays 0.
module scan_readback_intf #(
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int RESERVED_DATA_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  scan_readback_intf_if.slave bus,
  output logic [3:0]          dbg_state
);

  localparam int BIT_W = (MEMORY_DATA_WIDTH > 1) ? $clog2(MEMORY_DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(MEMORY_DATA_WIDTH - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CAP_C1  = 4'd1,
    CAP_GAP = 4'd2,
    CAP_C2  = 4'd3,
    SAMP    = 4'd4,
    SH_C1   = 4'd5,
    SH_GAP  = 4'd6,
    SH_C2   = 4'd7,
    WRITE   = 4'd8,
    DONE_S  = 4'd9
  } state_t;

  state_t                       state;
  logic [MEMORY_ADDR_WIDTH-1:0] addr;
  logic [RESERVED_DATA_LEN-1:0] len;
  logic [RESERVED_DATA_LEN-1:0] byte_cnt;
  logic [BIT_W-1:0]             bit_cnt;
  logic [MEMORY_DATA_WIDTH-1:0] shreg;

  assign dbg_state = state;

  // Each branch sets the registered outputs for the state being entered, so
  // the outputs always line up with the state register. Pulse outputs default
  // low and strobes default inactive every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      len       <= '0;
      byte_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      bus.sel   <= 1'b0;
      bus.sclk1 <= 1'b0;
      bus.sclk2 <= 1'b0;
      bus.si    <= 1'b0;
      bus.cen   <= 1'b1;
      bus.wen   <= 1'b1;
      bus.a     <= '0;
      bus.d     <= '0;
      bus.done  <= 1'b0;
    end else begin
      bus.sel   <= 1'b0;
      bus.sclk1 <= 1'b0;
      bus.sclk2 <= 1'b0;
      bus.cen   <= 1'b1;
      bus.wen   <= 1'b1;
      bus.done  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.bgn) begin
            if (bus.data_len != '0) begin
              state     <= CAP_C1;
              addr      <= bus.addr_bgn;
              len       <= bus.data_len;
              byte_cnt  <= '0;
              bit_cnt   <= '0;
              bus.sel   <= 1'b1;
              bus.sclk1 <= 1'b1;
            end else begin
              state    <= DONE_S;
              bus.done <= 1'b1;
            end
          end
        end
        CAP_C1: begin
          state   <= CAP_GAP;
          bus.sel <= 1'b1;
        end
        CAP_GAP: begin
          // sel drops together with the slave pulse. The slave latch only
          // copies the master latch, so sel has no effect on this pulse.
          state     <= CAP_C2;
          bus.sclk2 <= 1'b1;
        end
        CAP_C2: begin
          state <= SAMP;
        end
        SAMP: begin
          // so now shows the next chain bit. It enters the word MSB-side, so
          // after a full word the first bit read ends up in d[0].
          shreg     <= {bus.so, shreg[MEMORY_DATA_WIDTH-1:1]};
`ifdef SCAN_RB_RECIRC_EN
          bus.si    <= bus.so;
`else
          bus.si    <= 1'b0;
`endif
          state     <= SH_C1;
          bus.sclk1 <= 1'b1;
        end
        SH_C1: begin
          state <= SH_GAP;
        end
        SH_GAP: begin
          state     <= SH_C2;
          bus.sclk2 <= 1'b1;
        end
        SH_C2: begin
          if (bit_cnt == LAST_BIT) begin
            state   <= WRITE;
            bus.cen <= 1'b0;
            bus.wen <= 1'b0;
            bus.a   <= addr;
            bus.d   <= shreg;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            state   <= SAMP;
          end
        end
        WRITE: begin
          addr    <= addr + 1'b1;
          bit_cnt <= '0;
          if (byte_cnt == len - 1'b1) begin
            state    <= DONE_S;
            bus.done <= 1'b1;
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
            state    <= SAMP;
          end
        end
        DONE_S: begin
          // done stays high while bgn is held. A new transfer needs bgn to
          // go low first.
          if (!bus.bgn) begin
            state <= IDLE;
          end else begin
            bus.done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_readback_intf.sv
module tb_scan_readback_intf;
  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int LW    = 8;
  localparam int N     = 16;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scan_readback_intf_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();
  logic [3:0] dbg_state;

  scan_readback_intf #(
    .MEMORY_ADDR_WIDTH(AW),
    .MEMORY_DATA_WIDTH(DW),
    .RESERVED_DATA_LEN(LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- environment: LSSD chain and SRAM ----------------
  // Cell 0 drives so. si enters cell N-1. A shift moves cell i+1 into cell i.
  logic [N-1:0]  pin;
  logic [N-1:0]  master;
  logic [N-1:0]  slave;
  logic [DW-1:0] mem [0:DEPTH-1];
  assign bus.so = slave[0];

  int n_s1, n_s2, n_cap1, n_sel, n_overlap, n_cen, n_wr;

  // Registered DUT outputs are stable at the falling edge. Pulses last one cycle.
  always @(negedge clk) begin
    logic [N-1:0] nm;
    if (bus.sclk1 === 1'b1 && bus.sclk2 === 1'b1) n_overlap++;
    if (bus.sel === 1'b1) n_sel++;
    if (bus.sclk1 === 1'b1) begin
      n_s1++;
      if (bus.sel === 1'b1) n_cap1++;
      for (int i = 0; i < N; i++)
        nm[i] = (bus.sel === 1'b1) ? pin[i] : ((i == N - 1) ? bus.si : slave[i+1]);
      master = nm;
    end
    if (bus.sclk2 === 1'b1) begin
      n_s2++;
      slave = master;
    end
    if (bus.cen === 1'b0) begin
      n_cen++;
      if (bus.wen === 1'b0) begin
        n_wr++;
        mem[bus.a] = bus.d;
      end
    end
  end

  // ---------------- reference model ----------------
  // Readback bit b is chain bit b. With recirculation, bits past the chain
  // length repeat the captured pattern. Without it they read as zero.
  function automatic logic [DW-1:0] model_word(input logic [N-1:0] p, input int k);
    logic [DW-1:0] w;
    for (int j = 0; j < DW; j++) begin
      int b;
      b = k * DW + j;
`ifdef SCAN_RB_RECIRC_EN
      w[j] = p[b % N];
`else
      w[j] = (b < N) ? p[b] : 1'b0;
`endif
    end
    return w;
  endfunction

  function automatic logic [N-1:0] model_chain_after(input logic [N-1:0] p, input int nbits);
    logic [N-1:0] c;
    for (int i = 0; i < N; i++) begin
      int b;
      b = nbits + i;
`ifdef SCAN_RB_RECIRC_EN
      c[i] = p[b % N];
`else
      c[i] = (b < N) ? p[b] : 1'b0;
`endif
    end
    return c;
  endfunction

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // ---------------- driver tasks ----------------
  task automatic clear_env();
    for (int i = 0; i < DEPTH; i++) mem[i] = 'x;
    master    = N'($urandom);
    slave     = N'($urandom);
    n_s1      = 0;
    n_s2      = 0;
    n_cap1    = 0;
    n_sel     = 0;
    n_overlap = 0;
    n_cen     = 0;
    n_wr      = 0;
  endtask

  // Requests a transfer and returns the edge number, counted from the edge
  // that samples bgn=1 (edge 0), after which done is first seen high.
  // Returns -1 if done never rises. With scramble set, bgn and the start
  // inputs are disturbed after edge 2.
  task automatic run_xfer(input logic [N-1:0] p, input logic [AW-1:0] ad,
                          input logic [LW-1:0] ln, input bit scramble, output int lat);
    @(negedge clk);
    clear_env();
    pin          = p;
    bus.bgn      = 1'b1;
    bus.addr_bgn = ad;
    bus.data_len = ln;
    @(posedge clk);
    lat = -1;
    for (int e = 1; e <= 20000; e++) begin
      @(posedge clk);
      #1;
      if (scramble && e == 2) begin
        bus.bgn      = 1'b0;
        bus.addr_bgn = AW'($urandom);
        bus.data_len = LW'($urandom);
      end
      if (bus.done === 1'b1) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic end_xfer();
    @(negedge clk);
    bus.bgn = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  function automatic void load_expect(input logic [N-1:0] p, input int ln);
    exp_q.delete();
    for (int k = 0; k < ln; k++) exp_q.push_back(model_word(p, k));
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst          = 1'b1;
    bus.bgn      = 1'b0;
    bus.addr_bgn = '0;
    bus.data_len = '0;
    clear_env();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.sel, bus.sclk1, bus.sclk2, bus.si, bus.cen, bus.wen, bus.a, bus.d, bus.done}
        !== {4'b0000, 2'b11, {AW{1'b0}}, {DW{1'b0}}, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got sel=%b sclk1=%b sclk2=%b si=%b cen=%b wen=%b a=%h d=%h done=%b want 0 0 0 0 1 1 000 00 0",
               bus.sel, bus.sclk1, bus.sclk2, bus.si, bus.cen, bus.wen, bus.a, bus.d, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b0 || bus.cen !== 1'b1 || n_s1 != 0) begin
      bad++;
      $display("FAIL idle_quiet: got done=%b cen=%b sclk1_pulses=%0d want 0 1 0", bus.done, bus.cen, n_s1);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [N-1:0] exp_chain;
    load_expect(16'hA5C3, 2);
    run_xfer(16'hA5C3, 9'h010, 8'd2, 1'b0, lat);
    total++;
    if (lat != 69) begin
      bad++;
      $display("FAIL basic_latency: got %0d want 69", lat);
    end
    for (int k = 0; k < 2; k++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      total++;
      if (mem[9'h010 + k] !== e) begin
        bad++;
        $display("FAIL basic_word%0d: got %h want %h", k, mem[9'h010 + k], e);
      end
    end
    total++;
    if (mem[9'h010] !== 8'hC3 || mem[9'h011] !== 8'hA5) begin
      bad++;
      $display("FAIL basic_const: got %h %h want c3 a5", mem[9'h010], mem[9'h011]);
    end
    total++;
    if (n_overlap != 0 || n_cap1 != 1 || n_sel != 2 || n_s1 != 17 || n_s2 != 17) begin
      bad++;
      $display("FAIL basic_clocks: got overlap=%0d cap_sclk1=%0d sel_cycles=%0d sclk1=%0d sclk2=%0d want 0 1 2 17 17",
               n_overlap, n_cap1, n_sel, n_s1, n_s2);
    end
    total++;
    if (n_wr != 2 || n_cen != 2) begin
      bad++;
      $display("FAIL basic_writes: got writes=%0d cen_low=%0d want 2 2", n_wr, n_cen);
    end
    exp_chain = model_chain_after(16'hA5C3, 16);
    total++;
    if (slave !== exp_chain) begin
      bad++;
      $display("FAIL basic_chain_after: got %h want %h", slave, exp_chain);
    end
    // done holds while bgn stays high and no new transfer starts
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b1 || n_s1 != 17) begin
      bad++;
      $display("FAIL done_hold: got done=%b sclk1=%0d want 1 17", bus.done, n_s1);
    end
    @(negedge clk);
    bus.bgn = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("FAIL done_release: got %b want 0", bus.done);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_wrap();
    int lat;
    run_xfer(16'h0201, 9'h1FF, 8'd2, 1'b0, lat);
    total++;
    if (mem[9'h1FF] !== 8'h01 || mem[9'h000] !== 8'h02 || lat != 69) begin
      bad++;
      $display("FAIL wrap: got [1ff]=%h [000]=%h lat=%0d want 01 02 69", mem[9'h1FF], mem[9'h000], lat);
    end
    end_xfer();
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    clear_env();
    bus.bgn      = 1'b1;
    bus.addr_bgn = 9'h055;
    bus.data_len = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b1) begin
      bad++;
      $display("FAIL zero_len_done: got %b want 1", bus.done);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b1 || n_s1 != 0 || n_s2 != 0 || n_cen != 0) begin
      bad++;
      $display("FAIL zero_len_quiet: got done=%b sclk1=%0d sclk2=%0d cen_low=%0d want 1 0 0 0",
               bus.done, n_s1, n_s2, n_cen);
    end
    @(negedge clk);
    bus.bgn = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("FAIL zero_len_release: got %b want 0", bus.done);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    clear_env();
    pin          = 16'hA5C3;
    bus.bgn      = 1'b1;
    bus.addr_bgn = 9'h010;
    bus.data_len = 8'd2;
    @(posedge clk);                    // edge 0
    repeat (19) @(posedge clk);        // edge 19
    @(negedge clk);
    rst     = 1'b1;
    bus.bgn = 1'b0;
    @(posedge clk);                    // edge 20
    #1;
    total++;
    if ({bus.sel, bus.sclk1, bus.sclk2, bus.si, bus.cen, bus.wen, bus.a, bus.d, bus.done}
        !== {4'b0000, 2'b11, {AW{1'b0}}, {DW{1'b0}}, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_outputs: got sel=%b sclk1=%b sclk2=%b si=%b cen=%b wen=%b a=%h d=%h done=%b",
               bus.sel, bus.sclk1, bus.sclk2, bus.si, bus.cen, bus.wen, bus.a, bus.d, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (n_wr != 0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_nowrite: got writes=%0d done=%b want 0 0", n_wr, bus.done);
    end
    load_expect(16'h3C96, 2);
    run_xfer(16'h3C96, 9'h020, 8'd2, 1'b0, lat);
    total++;
    if (lat != 69) begin
      bad++;
      $display("FAIL reset_mid_restart_latency: got %0d want 69", lat);
    end
    for (int k = 0; k < 2; k++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      total++;
      if (mem[9'h020 + k] !== e) begin
        bad++;
        $display("FAIL reset_mid_restart_word%0d: got %h want %h", k, mem[9'h020 + k], e);
      end
    end
    end_xfer();
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [N-1:0]  p;
      logic [AW-1:0] ad;
      int            ln;
      bit            scr;
      int            lat;
      int            errs;
      p   = N'($urandom);
      ad  = AW'($urandom);
      ln  = $urandom_range(1, 4);
      scr = 1'($urandom_range(0, 1));
      load_expect(p, ln);
      run_xfer(p, ad, LW'(ln), scr, lat);
      total++;
      if (lat != 3 + 33 * ln) begin
        bad++;
        $display("FAIL rand%0d_latency: got %0d want %0d", it, lat, 3 + 33 * ln);
      end
      errs = 0;
      for (int k = 0; k < ln; k++) begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (mem[AW'(ad + k)] !== e) begin
          errs++;
          $display("FAIL rand%0d_word%0d: got %h want %h", it, k, mem[AW'(ad + k)], e);
        end
      end
      total++;
      if (errs != 0) bad++;
      total++;
      if (n_wr != ln || n_overlap != 0 || n_s1 != 1 + 8 * ln || n_s2 != 1 + 8 * ln) begin
        bad++;
        $display("FAIL rand%0d_protocol: got writes=%0d overlap=%0d sclk1=%0d sclk2=%0d want %0d 0 %0d %0d",
                 it, n_wr, n_overlap, n_s1, n_s2, ln, 1 + 8 * ln, 1 + 8 * ln);
      end
      total++;
      if (slave !== model_chain_after(p, 8 * ln)) begin
        bad++;
        $display("FAIL rand%0d_chain: got %h want %h", it, slave, model_chain_after(p, 8 * ln));
      end
      end_xfer();
    end
  endtask

  task automatic test_max_len();
    logic [N-1:0]  p;
    logic [AW-1:0] ad;
    int            lat;
    int            errs;
    p  = N'($urandom);
    ad = AW'($urandom_range(300, 511));
    load_expect(p, 255);
    run_xfer(p, ad, 8'd255, 1'b0, lat);
    total++;
    if (lat != 3 + 33 * 255) begin
      bad++;
      $display("FAIL max_len_latency: got %0d want %0d", lat, 3 + 33 * 255);
    end
    errs = 0;
    for (int k = 0; k < 255; k++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      if (mem[AW'(ad + k)] !== e) begin
        errs++;
        if (errs <= 4) $display("FAIL max_len_word%0d: got %h want %h", k, mem[AW'(ad + k)], e);
      end
    end
    total++;
    if (errs != 0) bad++;
    total++;
    if (n_wr != 255) begin
      bad++;
      $display("FAIL max_len_writes: got %0d want 255", n_wr);
    end
    end_xfer();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_len();
    test_reset_mid();
    test_random();
    test_max_len();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
